// File: rtl/mem_access_unit_if.sv
// Word-wide data-memory bus: mem_access_unit drives it as master, the memory answers as slave.
// Read data is combinational for the presented word address; writes land on the rising edge.
interface mem_access_unit_if #(
    parameter int N = 32
);
    logic [N-1:0] mem_address;
    logic [N-1:0] mem_write_data;
    logic [N-1:0] mem_read_data;
    logic         mem_write;
    logic         mem_read;

    modport master (
        output mem_address,
        output mem_write_data,
        output mem_write,
        output mem_read,
        input  mem_read_data
    );

    modport slave (
        input  mem_address,
        input  mem_write_data,
        input  mem_write,
        input  mem_read,
        output mem_read_data
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for a big-endian, byte-addressed, word-wide data memory:
// sub-word loads are extended, sub-word stores go through read-modify-write.
//   state    | meaning
//   S_IDLE   | waiting for a request; completion pulses show here
//   S_LD     | memory read, lane extracted and extended into load_data
//   S_ST     | full-word write of the latched data
//   S_RMW_RD | read the target word, merge the byte/half lane
//   S_RMW_WR | write the merged word
//   S_ERR    | rejected request, no memory access
module mem_access_unit #(
    parameter int N         = 32,
    parameter int MEM_BYTES = 1024
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_req_valid,
    input  logic             i_req_store,
    input  logic [1:0]       i_req_size,
    input  logic             i_req_signed,
    input  logic [N-1:0]     i_req_address,
    input  logic [N-1:0]     i_req_data,
    output logic             o_busy,
    output logic [N-1:0]     o_load_data,
    output logic             o_load_valid,
    output logic             o_store_done,
    output logic             o_access_err,
    mem_access_unit_if.master bus
);

    localparam logic [N-1:0] LP_WORD_LIMIT = N'(MEM_BYTES - 4);
    localparam logic [N-1:0] LP_BYTE_LIMIT = N'(MEM_BYTES);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD,
        S_ST,
        S_RMW_RD,
        S_RMW_WR,
        S_ERR
    } state_t;

    state_t       r_state;
    state_t       w_next;

    logic [N-1:0] r_word_addr;
    logic [1:0]   r_offset;
    logic [1:0]   r_size;
    logic         r_signed;
    logic [N-1:0] r_data;
    logic [N-1:0] r_merged;
    logic [N-1:0] r_load_data;
    logic         r_load_valid;
    logic         r_store_done;
    logic         r_access_err;

    logic         w_accept;
    logic         w_size_err;
    logic         w_align_err;
    logic         w_range_err;
    logic         w_req_err;
    logic [7:0]   w_lane_byte;
    logic [15:0]  w_lane_half;
    logic [N-1:0] w_load_ext;
    logic [N-1:0] w_merged;
    logic [N-1:0] w_mem_address;
    logic [N-1:0] w_mem_write_data;
    logic         w_mem_read;
    logic         w_mem_write;

    assign w_accept   = (r_state == S_IDLE) && i_req_valid;
    assign w_size_err = (i_req_size == SZ_BAD);
    assign w_align_err = ((i_req_size == SZ_HALF) && i_req_address[0]) ||
                         ((i_req_size == SZ_WORD) && (i_req_address[1:0] != 2'b00));
    assign w_range_err = (i_req_size == SZ_WORD) ? (i_req_address > LP_WORD_LIMIT)
                                                 : (i_req_address >= LP_BYTE_LIMIT);
    assign w_req_err  = w_size_err || w_align_err || w_range_err;

    // Offset 0 is the most significant lane of the word.
    always_comb begin
        w_lane_byte = bus.mem_read_data[7:0];
        case (r_offset)
            2'd0:    w_lane_byte = bus.mem_read_data[31:24];
            2'd1:    w_lane_byte = bus.mem_read_data[23:16];
            2'd2:    w_lane_byte = bus.mem_read_data[15:8];
            default: w_lane_byte = bus.mem_read_data[7:0];
        endcase
        w_lane_half = r_offset[1] ? bus.mem_read_data[15:0] : bus.mem_read_data[31:16];
    end

    always_comb begin
        w_load_ext = bus.mem_read_data;
        case (r_size)
            SZ_BYTE: w_load_ext = {{(N-8){r_signed & w_lane_byte[7]}}, w_lane_byte};
            SZ_HALF: w_load_ext = {{(N-16){r_signed & w_lane_half[15]}}, w_lane_half};
            default: w_load_ext = bus.mem_read_data;
        endcase
    end

    always_comb begin
        w_merged = bus.mem_read_data;
        if (r_size == SZ_BYTE) begin
            case (r_offset)
                2'd0:    w_merged[31:24] = r_data[7:0];
                2'd1:    w_merged[23:16] = r_data[7:0];
                2'd2:    w_merged[15:8]  = r_data[7:0];
                default: w_merged[7:0]   = r_data[7:0];
            endcase
        end else if (r_offset[1]) begin
            w_merged[15:0] = r_data[15:0];
        end else begin
            w_merged[31:16] = r_data[15:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next           = r_state;
        w_mem_address    = '0;
        w_mem_write_data = '0;
        w_mem_read       = 1'b0;
        w_mem_write      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_req_err) begin
                        w_next = S_ERR;
                    end else if (!i_req_store) begin
                        w_next = S_LD;
                    end else if (i_req_size == SZ_WORD) begin
                        w_next = S_ST;
                    end else begin
                        w_next = S_RMW_RD;
                    end
                end
            end
            S_LD: begin
                w_mem_read    = 1'b1;
                w_mem_address = r_word_addr;
                w_next        = S_IDLE;
            end
            S_ST: begin
                w_mem_write      = 1'b1;
                w_mem_address    = r_word_addr;
                w_mem_write_data = r_data;
                w_next           = S_IDLE;
            end
            S_RMW_RD: begin
                w_mem_read    = 1'b1;
                w_mem_address = r_word_addr;
                w_next        = S_RMW_WR;
            end
            S_RMW_WR: begin
                w_mem_write      = 1'b1;
                w_mem_address    = r_word_addr;
                w_mem_write_data = r_merged;
                w_next           = S_IDLE;
            end
            S_ERR: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_word_addr  <= '0;
            r_offset     <= '0;
            r_size       <= '0;
            r_signed     <= 1'b0;
            r_data       <= '0;
            r_merged     <= '0;
            r_load_data  <= '0;
            r_load_valid <= 1'b0;
            r_store_done <= 1'b0;
            r_access_err <= 1'b0;
        end else begin
            r_load_valid <= (r_state == S_LD);
            r_store_done <= (r_state == S_ST) || (r_state == S_RMW_WR);
            r_access_err <= (r_state == S_ERR);
            if (w_accept) begin
                r_word_addr <= {i_req_address[N-1:2], 2'b00};
                r_offset    <= i_req_address[1:0];
                r_size      <= i_req_size;
                r_signed    <= i_req_signed;
                r_data      <= i_req_data;
            end
            if (r_state == S_LD) begin
                r_load_data <= w_load_ext;
            end
            if (r_state == S_RMW_RD) begin
                r_merged <= w_merged;
            end
        end
    end

    assign o_busy             = (r_state != S_IDLE);
    assign o_load_data        = r_load_data;
    assign o_load_valid       = r_load_valid;
    assign o_store_done       = r_store_done;
    assign o_access_err       = r_access_err;
    assign bus.mem_address    = w_mem_address;
    assign bus.mem_write_data = w_mem_write_data;
    assign bus.mem_read       = w_mem_read;
    assign bus.mem_write      = w_mem_write;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a byte-array memory device plus a byte-level reference model,
// directed steps followed by randomized load/store/error traffic.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_address;
    logic [31:0] req_data;
    logic        busy;
    logic [31:0] load_data;
    logic        load_valid;
    logic        store_done;
    logic        access_err;

    mem_access_unit_if #(.N(32)) bus();

    mem_access_unit #(.N(32), .MEM_BYTES(1024)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_req_valid   (req_valid),
        .i_req_store   (req_store),
        .i_req_size    (req_size),
        .i_req_signed  (req_signed),
        .i_req_address (req_address),
        .i_req_data    (req_data),
        .o_busy        (busy),
        .o_load_data   (load_data),
        .o_load_valid  (load_valid),
        .o_store_done  (store_done),
        .o_access_err  (access_err),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    // Memory device seen by the DUT, and the independent reference image.
    logic [7:0]  mem     [0:1023];
    logic [7:0]  ref_mem [0:1023];
    logic        init_we;
    logic [9:0]  init_addr;
    logic [7:0]  init_byte;
    logic [9:0]  rd_base;
    logic [31:0] rd_word;

    always_comb begin
        rd_base = {bus.mem_address[9:2], 2'b00};
        rd_word = {mem[rd_base], mem[rd_base + 10'd1], mem[rd_base + 10'd2], mem[rd_base + 10'd3]};
    end

    assign bus.mem_read_data = rd_word;

    always @(posedge clk) begin
        if (init_we) begin
            mem[init_addr] <= init_byte;
        end else if (bus.mem_write) begin
            mem[rd_base]         <= bus.mem_write_data[31:24];
            mem[rd_base + 10'd1] <= bus.mem_write_data[23:16];
            mem[rd_base + 10'd2] <= bus.mem_write_data[15:8];
            mem[rd_base + 10'd3] <= bus.mem_write_data[7:0];
        end
    end

    int          n_pass  = 0;
    int          n_total = 0;
    int          n_fail  = 0;
    int          op_n    = 0;
    logic [31:0] exp_ld;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s op=%0d observed=%h expected=%h", tag, op_n, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [9:0] base);
        return {ref_mem[base], ref_mem[base + 10'd1], ref_mem[base + 10'd2], ref_mem[base + 10'd3]};
    endfunction

    function automatic logic [31:0] dev_word(input logic [9:0] base);
        return {mem[base], mem[base + 10'd1], mem[base + 10'd2], mem[base + 10'd3]};
    endfunction

    function automatic int size_bytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    // Big-endian: the lowest address is the most significant byte of the datum.
    function automatic logic [31:0] load_model(input logic [9:0] a, input logic [1:0] sz, input logic sg);
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < size_bytes(sz); k++) v = {v[23:0], ref_mem[a + 10'(k)]};
        if (sg && sz == 2'd0 && v[7])  v[31:8]  = '1;
        if (sg && sz == 2'd1 && v[15]) v[31:16] = '1;
        return v;
    endfunction

    // Issue one request at the current negedge and check it cycle by cycle through its pulse.
    // keep=1 leaves req_valid high with junk fields, so the caller must issue the next op at once.
    task automatic do_op(input logic st, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d, input bit keep);
        bit          err;
        int          nby;
        int          nb;
        logic [9:0]  base;
        logic [31:0] wr_word;
        logic [2:0]  exp_p;
        op_n++;
        nby  = size_bytes(sz);
        err  = (sz == 2'b11) || ((a % nby) != 0) || ((longint'(a) + nby) > 1024);
        base = {a[9:2], 2'b00};
        if (!err && st) begin
            for (int k = 0; k < nby; k++) ref_mem[a[9:0] + 10'(k)] = d[8*(nby-1-k) +: 8];
        end
        wr_word = ref_word(base);
        if (!err && !st) exp_ld = load_model(a[9:0], sz, sg);
        exp_p = err ? 3'b001 : (st ? 3'b010 : 3'b100);
        nb    = (!err && st && sz != 2'b10) ? 2 : 1;

        req_valid   = 1'b1;
        req_store   = st;
        req_size    = sz;
        req_signed  = sg;
        req_address = a;
        req_data    = d;
        @(negedge clk);
        req_valid   = keep;
        req_store   = 1'($urandom);
        req_size    = 2'($urandom);
        req_signed  = 1'($urandom);
        req_address = $urandom;
        req_data    = $urandom;

        for (int i = 0; i < nb; i++) begin
            check("busy", {31'd0, busy}, 32'd1);
            check("pulse_in_busy", {29'd0, load_valid, store_done, access_err}, 32'd0);
            if (err) begin
                check("err_no_mem", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
            end else if (!st || (sz != 2'b10 && i == 0)) begin
                check("rd_strobe", {30'd0, bus.mem_read, bus.mem_write}, 32'd2);
                check("rd_addr", bus.mem_address, {22'd0, base});
            end else begin
                check("wr_strobe", {30'd0, bus.mem_read, bus.mem_write}, 32'd1);
                check("wr_addr", bus.mem_address, {22'd0, base});
                check("wr_data", bus.mem_write_data, wr_word);
            end
            @(negedge clk);
        end

        check("busy_end", {31'd0, busy}, 32'd0);
        check("idle_strobe", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
        check("idle_addr", bus.mem_address, 32'd0);
        check("pulses", {29'd0, load_valid, store_done, access_err}, {29'd0, exp_p});
        check("load_data", load_data, exp_ld);
        check("mem_word", dev_word(base), wr_word);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired before the summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  r_sz;
        logic [31:0] r_a;
        int          r_sel;
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_store   = 1'b0;
        req_size    = 2'b00;
        req_signed  = 1'b0;
        req_address = '0;
        req_data    = '0;
        init_we     = 1'b0;
        init_addr   = '0;
        init_byte   = '0;
        exp_ld      = '0;

        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            init_we    = 1'b1;
            init_addr  = 10'(i);
            init_byte  = 8'($urandom);
            ref_mem[i] = init_byte;
        end
        @(negedge clk);
        init_we = 1'b0;
        @(negedge clk);

        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_load_data", load_data, 32'd0);
        check("rst_pulses", {29'd0, load_valid, store_done, access_err}, 32'd0);
        check("rst_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
        check("rst_addr", bus.mem_address, 32'd0);
        check("rst_wdata", bus.mem_write_data, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        do_op(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
        check("sw_mem", dev_word(10'h10), 32'hDEADBEEF);
        do_op(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1'b0);
        check("lb_11", load_data, 32'hFFFFFFAD);
        do_op(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0);
        check("lbu_13", load_data, 32'h000000EF);
        do_op(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0);
        check("lh_12", load_data, 32'hFFFFBEEF);
        do_op(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 1'b0);
        check("lhu_10", load_data, 32'h0000DEAD);

        do_op(1'b1, 2'b00, 1'b0, 32'h12, 32'h12345678, 1'b0);
        check("sb_mem", dev_word(10'h10), 32'hDEAD78EF);
        do_op(1'b1, 2'b01, 1'b0, 32'h10, 32'h0000AAAA, 1'b0);
        check("sh_mem", dev_word(10'h10), 32'hAAAA78EF);

        do_op(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 1'b0);
        do_op(1'b1, 2'b01, 1'b0, 32'h03, 32'h5555, 1'b0);
        do_op(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 1'b0);
        do_op(1'b0, 2'b00, 1'b1, 32'h400, 32'h0, 1'b0);

        do_op(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, 1'b0);
        do_op(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 1'b0);
        do_op(1'b1, 2'b01, 1'b1, 32'h3FE, 32'h0000C3A5, 1'b0);
        do_op(1'b0, 2'b00, 1'b1, 32'h3FF, 32'h0, 1'b0);
        do_op(1'b0, 2'b01, 1'b0, 32'h3FF, 32'h0, 1'b0);

        do_op(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, 1'b1);
        do_op(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0);
        check("b2b_lw", load_data, 32'hCAFEF00D);

        op_n++;
        req_valid   = 1'b1;
        req_store   = 1'b1;
        req_size    = 2'b00;
        req_signed  = 1'b0;
        req_address = 32'h15;
        req_data    = 32'h0000005A;
        @(negedge clk);
        req_valid = 1'b0;
        check("mid_rst_rd", {30'd0, bus.mem_read, bus.mem_write}, 32'd2);
        reset = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        exp_ld = '0;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
        check("mid_rst_load_data", load_data, 32'd0);
        @(negedge clk);
        check("mid_rst_no_done", {29'd0, load_valid, store_done, access_err}, 32'd0);
        check("mid_rst_mem", dev_word(10'h14), ref_word(10'h14));

        for (int i = 0; i < 400; i++) begin
            r_sz  = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            r_sel = int'($urandom_range(0, 9));
            if (r_sel == 0) r_a = 32'($urandom_range(1016, 1032));
            else            r_a = 32'($urandom_range(0, 1023));
            if (r_sel >= 2) r_a = r_a & ~(32'(size_bytes(r_sz)) - 32'd1);
            do_op(1'($urandom), r_sz, 1'($urandom), r_a, $urandom,
                  (i != 399) && ($urandom_range(0, 1) == 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage initiator for the word-wide, big-endian, byte-addressed data memory.
- Takes load/store requests from the pipeline (lb/lbu/lh/lhu/lw/sb/sh/sw) and issues word-aligned read/write cycles to the memory.
- Does read-modify-write for sub-word stores, and sign/zero-extends sub-word loads.
- Raises a stall (busy) to the pipeline while a request is in flight.

Parameters:
- n, 32, data/address width; only 32 is supported.
- MEM_BYTES, 1024, size of the memory in bytes; any address >= MEM_BYTES is a range error.

Ports:
- clk  input  1  clock; everything updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present; sampled only when busy=0.
- req_store  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 halfword, 10 word; 11 is illegal.
- req_signed  input  1  load sign-extend (lb/lh); ignored for stores and words.
- req_address  input  n  byte address.
- req_data  input  n  store data; sub-word data is taken from the LSBs.
- busy  output  1  pipeline stall; high whenever the state is not IDLE.
- load_data  output  n  extended load result; holds its value until the next load completes.
- load_valid  output  1  one-cycle pulse when load_data is updated.
- store_done  output  1  one-cycle pulse after the memory write cycle.
- access_err  output  1  one-cycle pulse for misaligned, range or illegal-size requests.
- mem_address  output  n  word-aligned address to memory (bits [1:0]=0).
- mem_write_data  output  n  word to write.
- mem_write  output  1  write strobe; memory writes on the rising edge.
- mem_read  output  1  read enable.
- mem_read_data  input  n  combinational read data for mem_address.

Behaviour:
- Byte ordering is big-endian. Offset 0 is bits [31:24], offset 3 is bits [7:0]. Halfword offset 0 is [31:16], offset 2 is [15:0].
- Request latching: on req_valid && !busy in IDLE, the request is latched into internal registers. The captured values are address, word address (address & ~3), offset, size, signed and data.
- Check order at accept:
  - Illegal size (11) -> error.
  - Halfword with address[0]=1, or word with address[1:0]!=0 -> error.
  - address > MEM_BYTES-4 for word, or >= MEM_BYTES for byte/half -> error.
- An error goes to state ERR. No memory access is made.
- States and transitions (every non-IDLE state lasts exactly one cycle):
  - IDLE: mem_read=0, mem_write=0, mem_address=0, mem_write_data=0.
  - LD: mem_read=1, mem_address=word address. At the edge, the selected byte/half/word is captured from mem_read_data and extended per the latched signed flag into load_data. load_valid=1 the next cycle. Goes to IDLE.
  - ST: mem_write=1, mem_write_data=latched data. store_done=1 the next cycle. Goes to IDLE.
  - RMW_RD (sb/sh): mem_read=1. At the edge, the word is captured with the target byte/half replaced by data[7:0] or data[15:0]. Goes to RMW_WR.
  - RMW_WR: mem_write=1, mem_write_data=merged word. store_done=1 the next cycle. Goes to IDLE.
  - ERR: access_err=1 the next cycle. Goes to IDLE.
- Latency:
  - Word load: accept at edge E, load_valid high in the cycle after edge E+1.
  - lw/sw/error occupy 1 busy cycle; sb/sh occupy 2 busy cycles.
- Pulse timing: load_valid, store_done and access_err are registered pulses, high in the first IDLE cycle after completion. A new request may be accepted in that same cycle, so back-to-back operation has no bubble beyond the busy cycles.
- Requests with busy=1 are ignored; the pipeline must hold its request stable.
- mem_read and mem_write are never high together.
- Only the addressed bytes change on sub-word stores.
- Reset in any state: next state IDLE and all outputs 0, including load_data. An in-flight RMW_RD never proceeds to its write. A reset asserted during RMW_WR cannot cancel that same edge's write.
- Extension rules: lbu/lhu zero-fill the upper bits. lb/lh replicate bit 7 or bit 15. req_signed is ignored for words.

Test Plan:
- Reset: hold reset 2 cycles -> all outputs 0 and busy=0. Then sw 0xDEADBEEF to 0x10 -> mem_write=1 for one cycle with mem_address=0x10; store_done pulses; busy high for 1 cycle.
- Loads after the sw, using 0x10=0xDEADBEEF:
  - lb 0x11 -> load_data=0xFFFFFFAD.
  - lbu 0x13 -> load_data=0x000000EF.
  - lh 0x12 -> load_data=0xFFFFBEEF.
  - lhu 0x10 -> load_data=0x0000DEAD.
  - Each gives load_valid for 1 cycle.
- RMW stores:
  - sb req_data=0x12345678 to 0x12 -> RMW_RD then RMW_WR writes 0xDEAD78EF.
  - sh 0xAAAA to 0x10 -> 0xAAAA78EF.
  - busy is high for 2 cycles for each.
- Errors: lw to 0x06, sh to 0x03, size=11, and lb to 0x400 -> each gives access_err for 1 cycle, with mem_read and mem_write never asserted.
- Back-to-back: lw issued in the cycle store_done pulses, with req_valid held through busy -> accepted with no idle gap; second request values are ignored while busy.
- Reset mid-operation: assert reset during RMW_RD of an sb -> no mem_write in the next cycle; returns to IDLE; no store_done is issued; memory is unchanged.
